seq_mul_acc: RTL

- Sequential radix-2 shift-add unsigned multiplier with accumulate: computes product = multiplicand * multiplier + addend.
- It is the inverse of the combinational restoring divider. Feeding quotient, divisor and remainder back in (q * d + r) must reconstruct the dividend exactly.
- It sits beside the divider in the arithmetic unit and uses the same n-bit carry-lookahead adder as its datapath adder.
- It uses a valid/ready handshake on both the input side and the output side.

---
 rtl/seq_mul_acc.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/seq_mul_acc.sv
// Sequential radix-2 shift-add unsigned multiply-accumulate: product = A*B + C.
// Ports: clk, rst_n, in_valid/in_ready + multiplicand/multiplier/addend in; out_valid/out_ready + product out; busy.

// n-bit carry-lookahead adder shared with the divider datapath.
// Ports: a_i, b_i operands, c_i carry-in; s_o sum, c_o carry-out.
module seq_mul_acc_cla #(
    parameter int W = 32
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    output logic [W-1:0] s_o,
    output logic         c_o
);
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;

    always_comb begin
        g    = a_i & b_i;
        p    = a_i ^ b_i;
        c    = '0;
        c[0] = c_i;
        for (int i = 0; i < W; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        s_o = p ^ c[W-1:0];
        c_o = c[W];
    end
endmodule

// Top: one RUN cycle per multiplier bit, then one ADD cycle folding in C.
// Ports: see spec-level summary in file banner above.
module seq_mul_acc #(
    parameter int n = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [n-1:0]   multiplicand,
    input  logic [n-1:0]   multiplier,
    input  logic [n-1:0]   addend,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*n-1:0] product,
    output logic           busy
);
    localparam int CW = $clog2(n);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        ADD,
        DONE
    } state_t;

    state_t           state_q;
    logic [2*n:0]     p_q;
    logic [n-1:0]     mcand_q;
    logic [n-1:0]     add_q;
    logic [CW-1:0]    cnt_q;
    logic [2*n-1:0]   product_q;
    logic             out_valid_q;
    logic             in_ready_q;
    logic             busy_q;

    logic [n-1:0]     add_a_d;
    logic [n-1:0]     add_b_d;
    logic [n-1:0]     sum_d;
    logic             co_d;
    logic [n:0]       upper_d;
    logic [n-1:0]     hi_d;

    // One adder serves both phases: upper half + A in RUN,
    // low half + C in ADD (its carry ripples into the upper half).
    always_comb begin
        if (state_q == ADD) begin
            add_a_d = p_q[n-1:0];
            add_b_d = add_q;
        end else begin
            add_a_d = p_q[2*n-1:n];
            add_b_d = mcand_q;
        end
    end

    seq_mul_acc_cla #(.W(n)) u_cla (
        .a_i (add_a_d),
        .b_i (add_b_d),
        .c_i (1'b0),
        .s_o (sum_d),
        .c_o (co_d)
    );

    assign upper_d = p_q[0] ? {co_d, sum_d} : p_q[2*n:n];
    assign hi_d    = p_q[2*n-1:n] + {{(n-1){1'b0}}, co_d};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            p_q         <= '0;
            mcand_q     <= '0;
            add_q       <= '0;
            cnt_q       <= '0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mcand_q    <= multiplicand;
                        add_q      <= addend;
                        p_q        <= {1'b0, {n{1'b0}}, multiplier};
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    // conditional add into upper half, then shift right
                    p_q   <= {1'b0, upper_d, p_q[n-1:1]};
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(n - 1)) begin
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    product_q   <= {hi_d, sum_d};
                    out_valid_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign product   = product_q;
    assign busy      = busy_q;
endmodule
